servo_slew_pwm: RTL

Multi-channel servo driver: holds a target angle and a slew rate per channel, moves each channel's position one degree at a time toward its target, and emits a hobby-servo PWM pulse per channel. Replaces the single-channel angle-to-compare-value block. It sits between the control/UI register logic and the servo output pins, and drives the pins directly instead of handing a compare value to a separate PWM stage.

---
 rtl/servo_pkg.sv | 27 ++
 rtl/servo_slew_ch.sv | 97 +++++++++
 rtl/servo_slew_pwm.sv | 108 ++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg
// Shared definitions for the multi-channel servo driver.
//   - Default timing constants for a 50 MHz system clock:
//       DEF_PERIOD_CNT  20 ms PWM frame
//       DEF_MIN_CNT     0.5 ms pulse at angle 0
//       DEF_DEG_CNT     extra pulse clocks per degree
//       DEF_STEP_CNT    clocks per one-degree step at slew rate 0
//   - rate_t: 2-bit slew rate; the step interval is STEP_CNT >> rate
//   - pulseWidth(): pulse length in clocks for a given position
package servo_pkg;

  localparam int unsigned DEF_PERIOD_CNT = 1000000;
  localparam int unsigned DEF_MIN_CNT    = 25000;
  localparam int unsigned DEF_DEG_CNT    = 555;
  localparam int unsigned DEF_STEP_CNT   = 32768;

  typedef logic [1:0] rate_t;

  // Computed at 32 bits; callers truncate to their phase width, which is
  // always large enough because the widest pulse must fit inside a frame.
  function automatic int unsigned pulseWidth(input int unsigned posVal,
                                             input int unsigned minCnt,
                                             input int unsigned degCnt);
    return minCnt + posVal * degCnt;
  endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// servo_slew_ch
// One servo channel: target/rate registers, slewing position with its step
// counter, and the per-frame pulse-width latch and compare.
// Ports:
//   iClk       system clock
//   iRst_n     synchronous active-low reset
//   iWrEn      write strobe already decoded for this channel
//   iWrAngle   new target angle (clamped to ANGLE_MAX here)
//   iWrRate    new slew rate
//   iPhase     this channel's position within the PWM frame
//   oPwm       registered servo pulse
//   oAtTarget  registered "position equals target"
//   oPos       current position
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int unsigned ANGLE_W    = 10,
  parameter int unsigned ANGLE_MAX  = 180,
  parameter int unsigned INIT_ANGLE = 90,
  parameter int unsigned PERIOD_CNT = DEF_PERIOD_CNT,
  parameter int unsigned MIN_CNT    = DEF_MIN_CNT,
  parameter int unsigned DEG_CNT    = DEF_DEG_CNT,
  parameter int unsigned STEP_CNT   = DEF_STEP_CNT,
  parameter int unsigned PW_W       = $clog2(DEF_PERIOD_CNT) + 1
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iWrEn,
  input  logic [ANGLE_W-1:0] iWrAngle,
  input  rate_t              iWrRate,
  input  logic [PW_W-1:0]    iPhase,
  output logic               oPwm,
  output logic               oAtTarget,
  output logic [ANGLE_W-1:0] oPos
);

  localparam int unsigned CNT_W = (STEP_CNT > 2) ? $clog2(STEP_CNT) : 1;
  localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] INIT_A = ANGLE_W'(INIT_ANGLE);
  localparam logic [PW_W-1:0] LAST_PHASE = PW_W'(PERIOD_CNT - 1);

  logic [ANGLE_W-1:0] target, targetNext, wrClamped;
  logic [ANGLE_W-1:0] pos, posNext;
  rate_t              rate, rateNext;
  logic [CNT_W-1:0]   stepCnt, stepCntNext, stepLimit;
  logic [PW_W-1:0]    widthNow, widthLatched;

  // Next-state logic. The step decision uses the registered target and
  // rate, so a write landing on a step cycle only takes effect afterwards.
  // The step counter is not touched by writes; it is only cleared by a
  // step or by arriving at the target.
  always_comb begin
    wrClamped   = (iWrAngle > MAX_A) ? MAX_A : iWrAngle;
    targetNext  = iWrEn ? wrClamped : target;
    rateNext    = iWrEn ? iWrRate : rate;
    stepLimit   = CNT_W'((STEP_CNT >> rate) - 32'd1);
    posNext     = pos;
    stepCntNext = '0;
    if (pos != target) begin
      if (stepCnt == stepLimit) begin
        stepCntNext = '0;
        posNext     = (pos < target) ? pos + ANGLE_W'(1) : pos - ANGLE_W'(1);
      end else begin
        stepCntNext = stepCnt + CNT_W'(1);
      end
    end
    widthNow = PW_W'(pulseWidth(32'(pos), MIN_CNT, DEG_CNT));
  end

  // The pulse width is captured on the clock where the phase wraps to 0,
  // so the whole frame uses one width. Reset clears the latch, which makes
  // the first frame after reset pulse-free.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      target       <= INIT_A;
      rate         <= '0;
      pos          <= INIT_A;
      stepCnt      <= '0;
      widthLatched <= '0;
      oPwm         <= 1'b0;
      oAtTarget    <= 1'b1;
    end else begin
      target    <= targetNext;
      rate      <= rateNext;
      pos       <= posNext;
      stepCnt   <= stepCntNext;
      oAtTarget <= (posNext == targetNext);
      if (iPhase == LAST_PHASE) begin
        widthLatched <= widthNow;
      end
      oPwm <= (iPhase < widthLatched);
    end
  end

  assign oPos = pos;

endmodule

// File: rtl/servo_slew_pwm.sv
// servo_slew_pwm
// Multi-channel hobby-servo driver with per-channel slew limiting.
// Each channel walks its position one degree at a time toward its target
// and drives a PWM pin whose pulse width follows the position, updated
// only at that channel's frame start.
// Build option:
//   SERVO_STAGGER_EN  spread the channel frame starts evenly across the
//                     frame (channel k lags by k*PERIOD_CNT/NCH clocks);
//                     when undefined, all channels start together.
// Ports:
//   iClk       system clock
//   iRst_n     synchronous active-low reset
//   iWrEn      write strobe for one channel's target and rate
//   iWrCh      channel index for the write (out-of-range is ignored)
//   iWrAngle   new target angle, clamped to ANGLE_MAX
//   iWrRate    new slew rate, step interval STEP_CNT >> rate
//   oPwm       servo pulse outputs, one per channel
//   oAtTarget  per-channel "position equals target"
//   oPos       positions, channel k at [k*ANGLE_W +: ANGLE_W]
module servo_slew_pwm
  import servo_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned ANGLE_W    = 10,
  parameter int unsigned ANGLE_MAX  = 180,
  parameter int unsigned INIT_ANGLE = 90,
  parameter int unsigned PERIOD_CNT = DEF_PERIOD_CNT,
  parameter int unsigned MIN_CNT    = DEF_MIN_CNT,
  parameter int unsigned DEG_CNT    = DEF_DEG_CNT,
  parameter int unsigned STEP_CNT   = DEF_STEP_CNT,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iWrEn,
  input  logic [CH_W-1:0]          iWrCh,
  input  logic [ANGLE_W-1:0]       iWrAngle,
  input  rate_t                    iWrRate,
  output logic [NCH-1:0]           oPwm,
  output logic [NCH-1:0]           oAtTarget,
  output logic [NCH*ANGLE_W-1:0]   oPos
);

  localparam int unsigned PW_W = $clog2(PERIOD_CNT) + 1;
  localparam logic [PW_W-1:0] FRAME_LAST = PW_W'(PERIOD_CNT - 1);

  // The widest pulse has to end before the frame does, otherwise the pin
  // would never go low between frames.
  if (MIN_CNT + ANGLE_MAX * DEG_CNT >= PERIOD_CNT) begin : gBadTiming
    $error("servo_slew_pwm: widest pulse does not fit inside the PWM frame");
  end

  logic [PW_W-1:0] frameCnt;

  // Shared frame counter, 0..PERIOD_CNT-1.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      frameCnt <= '0;
    end else if (frameCnt == FRAME_LAST) begin
      frameCnt <= '0;
    end else begin
      frameCnt <= frameCnt + PW_W'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : gCh
    logic [PW_W-1:0] phase;
    logic            wrSel;

`ifdef SERVO_STAGGER_EN
    localparam int unsigned PS_W = PW_W + 1;
    localparam int unsigned OFFS = (PERIOD_CNT - k * (PERIOD_CNT / NCH)) % PERIOD_CNT;
    logic [PS_W-1:0] phaseSum;
    // Both addends are below PERIOD_CNT, so one conditional subtract is
    // enough for the modulo.
    assign phaseSum = {1'b0, frameCnt} + PS_W'(OFFS);
    assign phase = (phaseSum >= PS_W'(PERIOD_CNT)) ?
                   PW_W'(phaseSum - PS_W'(PERIOD_CNT)) : PW_W'(phaseSum);
`else
    assign phase = frameCnt;
`endif

    // Indices at or above NCH match no channel, which drops the write.
    assign wrSel = iWrEn && (iWrCh == CH_W'(k));

    servo_slew_ch #(
      .ANGLE_W   (ANGLE_W),
      .ANGLE_MAX (ANGLE_MAX),
      .INIT_ANGLE(INIT_ANGLE),
      .PERIOD_CNT(PERIOD_CNT),
      .MIN_CNT   (MIN_CNT),
      .DEG_CNT   (DEG_CNT),
      .STEP_CNT  (STEP_CNT),
      .PW_W      (PW_W)
    ) uCh (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iWrEn    (wrSel),
      .iWrAngle (iWrAngle),
      .iWrRate  (iWrRate),
      .iPhase   (phase),
      .oPwm     (oPwm[k]),
      .oAtTarget(oAtTarget[k]),
      .oPos     (oPos[k*ANGLE_W +: ANGLE_W])
    );
  end

endmodule
